nios_fifo_rd_ctrl: RTL

//  Avalon-MM slave that lets the NIOS drain a hardware FIFO's read side. A burst

---
 rtl/nios_fifo_rd_pkg.sv | 27 ++
 rtl/nios_fifo_rd_fetch.sv | 95 +++++++++
 rtl/nios_fifo_rd_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/nios_fifo_rd_pkg.sv
// Shared register map, STATUS bit layout and fetch-state encoding for the FIFO read controller.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package nios_fifo_rd_pkg;

   // Avalon register addresses
   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_MASK   = 2'd2;
   localparam logic [1:0] ADDR_COUNT  = 2'd3;

   // STATUS register layout
   localparam int ST_VALID    = 0;
   localparam int ST_BUSY     = 1;
   localparam int ST_EMPTY    = 2;
   localparam int ST_DONE     = 3;
   localparam int ST_REM_LSB  = 16;
   localparam int REM_FIELD_W = 16;

   // Fetch sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/nios_fifo_rd_fetch.sv
// Fetch engine: issues one FIFO rdreq per word of a burst and holds the word until popped.
// Latency: rdreq one cycle after the fetch decision; word valid RD_LATENCY+1 cycles after rdreq.
// Backpressure: at most one word outstanding; no new rdreq while a word is held or FIFO is empty.
module nios_fifo_rd_fetch
   import nios_fifo_rd_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  count,
   input  logic              pop,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_q,
   output logic              fifo_rdreq,
   output logic [DATA_W-1:0] data_reg,
   output logic              valid,
   output logic [CNT_W-1:0]  remaining,
   output logic              last_capture
);

   // WAIT lasts RD_LATENCY cycles; the counter counts down to zero on the capture cycle.
   localparam logic [1:0] LAT_LOAD = 2'(RD_LATENCY - 1);

   fetch_state_t state, state_nxt;
   logic [1:0]   lat_cnt;
   logic         capture;
   logic         rem_nz;
   logic         load_ok;

   assign rem_nz       = (remaining != '0);
   // A new burst is only accepted when fully idle; zero length is a no-op.
   assign load_ok      = start && (count != '0) && !rem_nz && (state == IDLE);
   assign last_capture = capture && (remaining == CNT_W'(1));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next-state decode plus the rdreq and capture strobes
   always_comb begin
      state_nxt  = state;
      fifo_rdreq = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (rem_nz && !valid && !fifo_empty) state_nxt = REQ;
         end
         REQ: begin
            fifo_rdreq = 1'b1;
            state_nxt  = WAIT;
         end
         WAIT: begin
            if (lat_cnt == 2'd0) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Read-latency counter, loaded as the request goes out
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                              lat_cnt <= 2'd0;
      else if (state == REQ)                     lat_cnt <= LAT_LOAD;
      else if (state == WAIT && lat_cnt != 2'd0) lat_cnt <= lat_cnt - 2'd1;
   end

   // Words left in the burst; never decrements past zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                remaining <= '0;
      else if (load_ok)            remaining <= count;
      else if (capture && rem_nz)  remaining <= remaining - CNT_W'(1);
   end

   // Captured word and its valid flag; a pop with nothing held changes nothing
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg <= '0;
         valid    <= 1'b0;
      end else if (capture) begin
         data_reg <= fifo_q;
         valid    <= 1'b1;
      end else if (pop) begin
         valid    <= 1'b0;
      end
   end

endmodule

// File: rtl/nios_fifo_rd_ctrl.sv
// Avalon-MM slave letting the CPU drain a FIFO read port word by word with valid/done interrupts.
// Latency: readdata registered, one cycle after address; irq is a direct decode of registers.
// Backpressure: no waitrequest; a held word stalls further FIFO reads until the CPU pops it.
module nios_fifo_rd_ctrl
   import nios_fifo_rd_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int CNT_W      = 16,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              read_n,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic              irq,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_q,
   output logic              fifo_rdreq
);

   logic              wr_stb, rd_stb;
   logic              count_wr, mask_wr, done_w1c, pop;
   logic [1:0]        mask;
   logic              done;
   logic [DATA_W-1:0] data_reg;
   logic              valid;
   logic [CNT_W-1:0]  remaining;
   logic              last_capture;
   logic [31:0]       status_word;
   logic [31:0]       rd_mux;
   logic              writedata_unused;

   assign wr_stb   = chipselect && !write_n;
   assign rd_stb   = chipselect && !read_n;
   assign count_wr = wr_stb && (address == ADDR_COUNT);
   assign mask_wr  = wr_stb && (address == ADDR_MASK);
   assign done_w1c = wr_stb && (address == ADDR_STATUS) && writedata[ST_DONE];
   assign pop      = rd_stb && (address == ADDR_DATA);

   // Only a few writedata bits carry meaning; fold the rest away.
   assign writedata_unused = ^writedata;

   nios_fifo_rd_fetch #(
      .DATA_W     (DATA_W),
      .CNT_W      (CNT_W),
      .RD_LATENCY (RD_LATENCY)
   ) u_fetch (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (count_wr),
      .count        (writedata[CNT_W-1:0]),
      .pop          (pop),
      .fifo_empty   (fifo_empty),
      .fifo_q       (fifo_q),
      .fifo_rdreq   (fifo_rdreq),
      .data_reg     (data_reg),
      .valid        (valid),
      .remaining    (remaining),
      .last_capture (last_capture)
   );

   // Interrupt enables
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     mask <= 2'b00;
      else if (mask_wr) mask <= writedata[1:0];
   end

   // Burst-done flag: set by the final capture, which beats a same-cycle clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)          done <= 1'b0;
      else if (last_capture) done <= 1'b1;
      else if (done_w1c)     done <= 1'b0;
   end

   // STATUS word assembly
   always_comb begin
      status_word                                 = '0;
      status_word[ST_VALID]                       = valid;
      status_word[ST_BUSY]                        = (remaining != '0);
      status_word[ST_EMPTY]                       = fifo_empty;
      status_word[ST_DONE]                        = done;
      status_word[ST_REM_LSB +: REM_FIELD_W]      = REM_FIELD_W'(remaining);
   end

   // Read mux on the current address
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:   rd_mux = 32'(data_reg);
         ADDR_STATUS: rd_mux = status_word;
         ADDR_MASK:   rd_mux = {30'd0, mask};
         default:     rd_mux = '0;
      endcase
   end

   // Registered read data, refreshed every cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) readdata <= '0;
      else          readdata <= rd_mux;
   end

   assign irq = (valid && mask[0]) || (done && mask[1]);

endmodule
